// File: rtl/icu_wide.sv
// icu_wide: WIDTH-lane MC14500-style control unit with lane masks, cycle enable and one-deep skip
module icu_wide #(
  parameter int WIDTH = 4,
  parameter bit SKZ_ANY = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       instr,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] data_oe,
  output logic             write,
  output logic [WIDTH-1:0] rr,
  output logic             jmp,
  output logic             rtn,
  output logic             flag_o,
  output logic             flag_f,
  output logic             skip
);
  localparam logic [3:0] OP_NOPO = 4'd0, OP_LD = 4'd1, OP_LDC = 4'd2, OP_AND = 4'd3,
                         OP_ANDC = 4'd4, OP_OR = 4'd5, OP_ORC = 4'd6, OP_XNOR = 4'd7,
                         OP_STO = 4'd8, OP_STOC = 4'd9, OP_IEN = 4'd10, OP_OEN = 4'd11,
                         OP_JMP = 4'd12, OP_RTN = 4'd13, OP_SKZ = 4'd14;
  logic [WIDTH-1:0] ien, oen, d, rr_n, ien_n, oen_n, dout_n, oe_n;
  logic skip_n, jmp_n, rtn_n, fo_n, ff_n;
  assign d = data_in & ien;
  assign write = |data_oe;
  // data_out clears on any enabled edge that is not a store, but holds through stalls
  always_comb begin
    rr_n = rr;
    ien_n = ien;
    oen_n = oen;
    dout_n = data_out;
    oe_n = '0;
    skip_n = skip;
    jmp_n = 1'b0;
    rtn_n = 1'b0;
    fo_n = 1'b0;
    ff_n = 1'b0;
    if (en) begin
      dout_n = '0;
      skip_n = 1'b0;
      if (!skip)
        case (instr)
          OP_NOPO: fo_n = 1'b1;
          OP_LD:   rr_n = d;
          OP_LDC:  rr_n = ~d;
          OP_AND:  rr_n = rr & d;
          OP_ANDC: rr_n = rr & ~d;
          OP_OR:   rr_n = rr | d;
          OP_ORC:  rr_n = rr | ~d;
          OP_XNOR: rr_n = ~(rr ^ d);
          OP_STO:  begin dout_n = rr; oe_n = oen; end
          OP_STOC: begin dout_n = ~rr; oe_n = oen; end
          OP_IEN:  ien_n = data_in;
          OP_OEN:  oen_n = data_in;
          OP_JMP:  jmp_n = 1'b1;
          OP_RTN:  begin rtn_n = 1'b1; skip_n = 1'b1; end
          OP_SKZ:  skip_n = SKZ_ANY ? (rr == '0) : ~rr[0];
          default: ff_n = 1'b1;
        endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rr <= '0;
      ien <= '0;
      oen <= '0;
      data_out <= '0;
      data_oe <= '0;
      skip <= 1'b0;
      jmp <= 1'b0;
      rtn <= 1'b0;
      flag_o <= 1'b0;
      flag_f <= 1'b0;
    end else begin
      rr <= rr_n;
      ien <= ien_n;
      oen <= oen_n;
      data_out <= dout_n;
      data_oe <= oe_n;
      skip <= skip_n;
      jmp <= jmp_n;
      rtn <= rtn_n;
      flag_o <= fo_n;
      flag_f <= ff_n;
    end
  end
endmodule

// File: doc/icu_wide.md
# icu_wide

Parametrised successor to the team's 1-bit MC14500-style industrial control unit. Executes the same 16-opcode instruction set on a WIDTH-bit result register (RR), with per-lane input/output enable masks, a cycle-enable for stalling, and a selectable SKZ zero test. Sits behind the user-project wrapper. The external program counter / ROM sequencer drives `instr` and the data bus, and consumes the `jmp`/`rtn`/flag pulses.

## Interface
- `WIDTH`, 4, RR/data lane count, legal range 1..32.
- `SKZ_ANY`, 1, SKZ skip test. 1: skip when all of `rr` == 0. 0: skip when `rr[0]` == 0.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  cycle enable. When 0: no state change and all pulse outputs are 0 on the next edge.
- `instr`  in  4  opcode: 0 NOPO, 1 LD, 2 LDC, 3 AND, 4 ANDC, 5 OR, 6 ORC, 7 XNOR, 8 STO, 9 STOC, 10 IEN, 11 OEN, 12 JMP, 13 RTN, 14 SKZ, 15 NOPF.
- `data_in`  in  WIDTH  input data bus.
- `data_out`  out  WIDTH  store data. Valid while `write` is 1.
- `data_oe`  out  WIDTH  per-lane output enable for the store cycle.
- `write`  out  1  equals |`data_oe`.
- `rr`  out  WIDTH  result register.
- `jmp`, `rtn`, `flag_o`, `flag_f`  out  1  one-cycle pulses.
- `skip`  out  1  skip flag; the next enabled instruction will be suppressed.

## Operation
- Internal state: `rr`[WIDTH], `ien`[WIDTH], `oen`[WIDTH], `skip`.
- Masked input D = `data_in` & `ien`.
- Per opcode, on an enabled and non-skipped edge:
  - LD: `rr` <= D.
  - LDC: `rr` <= ~D.
  - AND: `rr` <= `rr` & D.
  - ANDC: `rr` <= `rr` & ~D.
  - OR: `rr` <= `rr` | D.
  - ORC: `rr` <= `rr` | ~D.
  - XNOR: `rr` <= ~(`rr` ^ D).
  - IEN: `ien` <= `data_in`, unmasked.
  - OEN: `oen` <= `data_in`, unmasked.
  - STO: `data_out` <= `rr`, `data_oe` <= `oen`.
  - STOC: `data_out` <= ~`rr`, `data_oe` <= `oen`.
  - JMP: `jmp` pulses.
  - RTN: `rtn` pulses and `skip` <= 1 unconditionally.
  - SKZ: `skip` <= zero-test(`rr`), using the test selected by SKZ_ANY.
  - NOPO: `flag_o` pulses.
  - NOPF: `flag_f` pulses.
- Skipped instruction: an enabled edge with `skip`=1 performs no state change and produces no pulse, `write` or `data_oe`. `skip` clears on that edge. This applies to every opcode, including SKZ and RTN.
- Skip is at most one instruction deep. A skipped SKZ/RTN does not re-arm `skip`.
- `en`=0 edge: every register holds, including `skip`. `jmp`, `rtn`, `flag_o`, `flag_f`, `data_oe` and `write` go to 0. `data_out` holds.
- Stores with `oen`=0 produce `write`=0, even though the opcode executed.
- Arithmetic is purely bitwise per lane; there is no carry or cross-lane interaction except the SKZ_ANY reduction.

## Timing
- Reset (`rst`=1 at an edge, regardless of `en`): `rr`, `ien`, `oen`, `data_out` and `data_oe` <= 0. `write`, `jmp`, `rtn`, `flag_o`, `flag_f` and `skip` <= 0.
- Reset wins over everything. A pending skip or an in-flight store is cancelled.
- Latency: `instr` and `data_in` are sampled at edge N. `rr`, the masks and all pulse outputs are valid after edge N and hold until edge N+1.
- Pulses last exactly one cycle. Back-to-back identical opcodes yield a continuous high level, one cycle per instruction.
- Store: `data_out` and `data_oe` are registered at the STO/STOC edge and cleared at the next edge, unless that edge is another store.
- Reads of D in the same cycle as IEN use the old `ien`. The new mask applies from the next instruction.
- `skip` is visible the cycle after SKZ/RTN and clears after the next enabled edge.

## Test plan
1. Reset, then `rst` low. Expect all outputs 0. Then NOPO → `flag_o`=1 for one cycle. Then NOPF → `flag_f`=1 and `flag_o`=0.
2. Logic ops, WIDTH=4. IEN `data_in`=F, then LD A → `rr`=A. Then OR 5 → F. Then ANDC 3 → C. Then XNOR 9 → A. Then LDC 6 → 9. Then ORC F → 9.
3. Stores with masks. OEN 6, `rr`=A, STO → `write`=1, `data_oe`=6, `data_out`=A for one cycle, then 0. STOC → `data_out`=5. OEN 0 then STO → `write`=0.
4. Skip semantics.
   - `rr`=0, SKZ, NOPF → no `flag_f`, `skip` clears.
   - `rr`=1, SKZ, NOPF → `flag_f`=1.
   - RTN → `rtn`=1, and the following JMP is suppressed (`jmp`=0).
   - SKZ_ANY=0 with `rr`=2 → SKZ skips.
5. Input masking and stall.
   - IEN 3, then LD F → `rr`=3.
   - `en`=0 for 3 cycles while `instr`=LD, `data_in`=0 → `rr` stays 3, no pulses, pending `skip` preserved.
   - Mid-sequence: `rst` during a store cycle → `write`=0 next cycle, `ien`/`oen`=0.
